// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers,
// with packet lock, start timeout on the UART busy handshake and lock-idle release.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic                   uart_busy_i,
  output logic                   uart_write_o,
  output logic [7:0]             uart_data_o,
  output logic [2:0]             owner_o,
  output logic                   locked_o,
  output logic                   start_err_o
);

  localparam int SCW = $clog2(START_TIMEOUT + 1);
  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [2:0]       pointer, owner, win;
  logic             locked, last_cap, start_err, found;
  logic [7:0]       data_q;
  logic [SCW-1:0]   start_cnt;
  logic [LCW-1:0]   lock_cnt;
  logic [7:0]       valid_ext, last_ext, ready_one;
  logic [63:0]      data_ext;
  logic [3:0]       idx, sum;
  logic             grant, start_expire, done, lock_idle, lock_expire;

  function automatic logic [2:0] inc_wrap(input logic [2:0] v);
    return (v == 3'(NUM_REQ - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  assign valid_ext = 8'(req_valid_i);
  assign last_ext  = 8'(req_last_i);
  assign data_ext  = 64'(req_data_i);

  // Winner selection: the lock owner only, otherwise first valid from the pointer onward.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 4'd0;
    sum   = 4'd0;
    if (locked) begin
      found = valid_ext[owner];
      win   = owner;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        sum   = {1'b0, pointer} + 4'(i);
        idx   = (sum >= 4'(NUM_REQ)) ? sum - 4'(NUM_REQ) : sum;
        win   = (!found && valid_ext[idx[2:0]]) ? idx[2:0] : win;
        found = found | valid_ext[idx[2:0]];
      end
    end
  end

  assign grant        = (state == IDLE) && !uart_busy_i && found;
  assign start_expire = (state == WAIT_START) && !uart_busy_i &&
                        (start_cnt == SCW'(START_TIMEOUT - 1));
  assign done         = start_expire || ((state == WAIT_DONE) && !uart_busy_i);
  assign lock_idle    = (state == IDLE) && locked && !valid_ext[owner];
  assign lock_expire  = lock_idle && (lock_cnt == LCW'(LOCK_TIMEOUT - 1));
  assign ready_one    = 8'd1 << win;

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       state_next = grant ? ISSUE : IDLE;
      ISSUE:      state_next = WAIT_START;
      WAIT_START: begin
        if (uart_busy_i) begin
          state_next = WAIT_DONE;
        end else begin
          state_next = start_expire ? IDLE : WAIT_START;
        end
      end
      WAIT_DONE:  state_next = uart_busy_i ? WAIT_DONE : IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode; the accept pulse is combinational so the winner sees it in the grant cycle.
  always_comb begin
    req_ready_o  = {NUM_REQ{1'b0}};
    uart_write_o = 1'b0;
    if (grant) begin
      req_ready_o = ready_one[NUM_REQ-1:0];
    end else begin
      req_ready_o = {NUM_REQ{1'b0}};
    end
    uart_write_o = (state == ISSUE);
  end

  // Byte capture, lock/pointer bookkeeping and the two timeout counters.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pointer   <= 3'd0;
      owner     <= 3'd0;
      locked    <= 1'b0;
      last_cap  <= 1'b0;
      data_q    <= 8'd0;
      start_err <= 1'b0;
      start_cnt <= {SCW{1'b0}};
      lock_cnt  <= {LCW{1'b0}};
    end else begin
      start_err <= start_expire;
      if (grant) begin
        data_q   <= data_ext[{win, 3'b000} +: 8];
        owner    <= win;
        last_cap <= last_ext[win];
      end
      if (done) begin
        locked  <= ~last_cap;
        pointer <= last_cap ? inc_wrap(owner) : pointer;
      end else if (lock_expire) begin
        locked  <= 1'b0;
        pointer <= inc_wrap(owner);
      end
      start_cnt <= ((state == WAIT_START) && !start_expire) ? start_cnt + SCW'(1) : {SCW{1'b0}};
      lock_cnt  <= (lock_idle && !lock_expire) ? lock_cnt + LCW'(1) : {LCW{1'b0}};
    end
  end

  assign uart_data_o = data_q;
  assign owner_o     = owner;
  assign locked_o    = locked;
  assign start_err_o = start_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (write/data/busy interface) among NUM_REQ byte producers using round-robin arbitration with optional packet lock.
- Sequences each byte: accept from the winner, pulse the UART write strobe, wait for busy to rise, then wait for it to fall.
- Sits between on-chip message sources (debug console, status reporter, etc.) and the UART's transmit side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 8, cycles to wait for busy to rise after a write strobe.
- LOCK_TIMEOUT, 1024, idle cycles before a held packet lock is forcibly released.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester byte valid; must hold until accepted.
- req_data_i  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  NUM_REQ  1 = byte ends packet, releases lock; 0 = keep lock.
- req_ready_o  out  NUM_REQ  one-hot accept pulse.
- uart_busy_i  in  1  UART transmitter busy.
- uart_write_o  out  1  one-cycle write strobe to the UART.
- uart_data_o  out  8  byte to the UART, stable from strobe until return to IDLE.
- owner_o  out  3  index of current or last granted requester.
- locked_o  out  1  packet lock held by owner_o.
- start_err_o  out  1  one-cycle pulse on START_TIMEOUT expiry.

Behaviour:
- Interface fixed: one clock (clock_i); reset (reset_i) is synchronous and active-high.
- Reset values:
  - Outputs: req_ready_o=0, uart_write_o=0, uart_data_o=0, owner_o=0, locked_o=0, start_err_o=0.
  - Internal: state=IDLE, priority pointer=0, all counters=0.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - Grants only when uart_busy_i=0.
  - If locked_o=1: only owner_o is eligible.
  - Otherwise: the first valid requester searching pointer, pointer+1, ... (mod NUM_REQ) wins.
  - Winner gets req_ready_o=1 combinationally in that cycle; data is registered into uart_data_o, owner_o is updated, req_last_i is captured; next state ISSUE.
  - No eligible requester: stay in IDLE; all ready outputs 0.
- ISSUE:
  - uart_write_o=1 for exactly this cycle, then WAIT_START.
  - Latency: accept in cycle N -> strobe in cycle N+1.
- WAIT_START:
  - uart_busy_i=1 -> WAIT_DONE.
  - Counter reaches START_TIMEOUT cycles without busy -> pulse start_err_o, treat byte as sent, apply completion rules, go to IDLE.
- WAIT_DONE:
  - uart_busy_i=0 -> apply completion rules, go to IDLE (the busy low is also seen by IDLE next cycle, so back-to-back bytes are allowed).
- Completion rules:
  - Captured last=1: locked_o=0, pointer = owner+1 mod NUM_REQ.
  - Captured last=0: locked_o=1, pointer unchanged.
- Lock timeout:
  - Counts IDLE cycles while locked_o=1 and the owner's valid is low.
  - At LOCK_TIMEOUT: clear locked_o, pointer = owner+1.
  - Counter clears on any accept.
- Non-owner valid while locked: ignored, ready stays 0, no data loss (requester holds).
- Valid deasserted before accept: no effect; not an error.
- Reset mid-operation: returns to IDLE with reset values. The UART may still be busy; IDLE waits for uart_busy_i=0 before granting. The in-flight byte is not retried.
- Pointer wrap: NUM_REQ-1 -> 0.
- owner_o: width 3 regardless of NUM_REQ; upper bits zero.

Test Plan:
- Single byte: reset, req0 valid with 0x41 and last=1; UART busy rises 1 cycle after strobe, held 20 cycles -> ready0 at N, strobe at N+1 with uart_data_o=0x41, next grant no earlier than busy fall.
- Round robin: all 4 valid continuously with last=1, data 0x10..0x13 -> strobe order 0,1,2,3,0; pointer wraps.
- Packet lock: req1 sends 0xA0 (last=0), 0xA1 (last=0), 0xA2 (last=1); req2 valid throughout -> req2 not granted until after 0xA2; then owner_o=2.
- Lock timeout (LOCK_TIMEOUT=16): req3 sends last=0 then drops valid; req0 valid -> locked_o clears after 16 idle cycles, req0 granted next.
- Start timeout: hold uart_busy_i=0 after strobe -> start_err_o pulses exactly 8 cycles after WAIT_START entry; next pending requester granted.
- Reset mid-WAIT_DONE with uart_busy_i=1 -> outputs return to reset values; no grant until busy falls, then req0 served first.
